// File: rtl/cp0_unit.sv
// Coprocessor-0: Status/Cause/EPC registers, interrupt capture and the exception/halt/ERET
// sequencer that drives pipeline flushes and the redirect PC.
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0004,
    parameter logic [31:0] HALT_VECTOR = 32'h0000_0008,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex,
    input  logic [4:0]  ex_code,
    input  logic        branch_delay,
    input  logic        eret_flush,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_rdc,
    input  logic [31:0] cp0_wdata,
    input  logic [31:0] id_pc,
    input  logic        stall,
    input  logic [7:0]  int_in,
    output logic [31:0] cp0_rdata,
    output logic        cp0_flush,
    output logic        ex_wb,
    output logic        cp0_eret,
    output logic        cp0_hlt,
    output logic        cp0_ie,
    output logic        cp0_exl,
    output logic [7:0]  cp0_int_mask,
    output logic [7:0]  cp0_int_sig,
    output logic [31:0] exc_addr
);

    localparam logic [4:0] CODE_HLT    = 5'd1;
    localparam logic [4:0] CODE_RESUME = 5'd2;
    localparam logic [4:0] IDX_STATUS  = 5'd12;
    localparam logic [4:0] IDX_CAUSE   = 5'd13;
    localparam logic [4:0] IDX_EPC     = 5'd14;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EXC  = 2'd1,
        ST_HALT = 2'd2,
        ST_ERET = 2'd3
    } state_t;

    // Selects the highest pending line among IP[5:0]; IP[7:6] belong to HLT/RESUME.
    function automatic logic [7:0] int_clr_mask(input logic [7:0] ip);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (ip[i]) begin
                m = 8'h01 << i;
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    state_t      state_r, state_next_s;
    logic [7:0]  sync_r [SYNC_STAGES];
    logic [7:0]  int_prev_r;
    logic [7:0]  int_rise_s;

    logic        ie_r, exl_r, bd_r;
    logic [7:0]  im_r, ip_r;
    logic [4:0]  code_r;
    logic [31:0] epc_r;

    logic        ie_next_s, exl_next_s, bd_next_s;
    logic [7:0]  im_next_s, ip_next_s, ip_clr_s;
    logic [4:0]  code_next_s;
    logic [31:0] epc_next_s;
    logic        mtc0_s;

    logic        flush_r, ex_wb_r, eret_r, hlt_r;
    logic [31:0] exc_addr_r;
    logic        flush_next_s, ex_wb_next_s, eret_next_s, hlt_next_s;
    logic [31:0] exc_addr_next_s;

    // Interrupt synchroniser chain plus the previous synchronised value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 8'h00;
            end
            int_prev_r <= 8'h00;
        end else begin
            sync_r[0] <= int_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            int_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign int_rise_s = sync_r[SYNC_STAGES-1] & ~int_prev_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, register-update and next-output logic.
    always_comb begin
        state_next_s = state_r;
        ie_next_s    = ie_r;
        exl_next_s   = exl_r;
        im_next_s    = im_r;
        bd_next_s    = bd_r;
        code_next_s  = code_r;
        epc_next_s   = epc_r;
        ip_clr_s     = 8'h00;
        mtc0_s       = cp0_we && !stall && (state_r == ST_RUN);

        // MTC0 goes first so exception entry below overrides the fields it owns.
        if (mtc0_s && (cp0_rdc == IDX_STATUS)) begin
            ie_next_s  = cp0_wdata[0];
            exl_next_s = cp0_wdata[1];
            im_next_s  = cp0_wdata[15:8];
        end else if (mtc0_s && (cp0_rdc == IDX_EPC)) begin
            epc_next_s = cp0_wdata;
        end else begin
            ie_next_s = ie_r;
        end

        case (state_r)
            ST_RUN: begin
                if (ex) begin
                    epc_next_s   = branch_delay ? (id_pc - 32'd4) : id_pc;
                    bd_next_s    = branch_delay;
                    code_next_s  = ex_code;
                    exl_next_s   = 1'b1;
                    state_next_s = ST_EXC;
                    case (ex_code)
                        CODE_HLT:    ip_clr_s = 8'h80;
                        CODE_RESUME: ip_clr_s = 8'h40;
                        default:     ip_clr_s = int_clr_mask(ip_r);
                    endcase
                end else if (eret_flush) begin
                    exl_next_s   = 1'b0;
                    state_next_s = ST_ERET;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_EXC: begin
                state_next_s = (code_r == CODE_HLT) ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (ex && (ex_code == CODE_RESUME)) begin
                    exl_next_s   = 1'b0;
                    code_next_s  = CODE_RESUME;
                    ip_clr_s     = 8'h40;
                    state_next_s = ST_EXC;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_ERET: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase

        // A new rising edge beats any clear landing on the same cycle.
        ip_next_s = (((mtc0_s && (cp0_rdc == IDX_CAUSE)) ? cp0_wdata[15:8] : ip_r)
                     & ~ip_clr_s) | int_rise_s;

        flush_next_s = (state_next_s == ST_EXC) || (state_next_s == ST_ERET);
        ex_wb_next_s = (state_next_s == ST_EXC);
        eret_next_s  = (state_next_s == ST_ERET);
        hlt_next_s   = (state_next_s == ST_HALT);

        case (state_next_s)
            ST_EXC:  exc_addr_next_s = (code_next_s == CODE_HLT) ? HALT_VECTOR : EXC_VECTOR;
            ST_ERET: exc_addr_next_s = epc_next_s;
            ST_HALT: exc_addr_next_s = HALT_VECTOR;
            ST_RUN:  exc_addr_next_s = ((state_r == ST_EXC) && (code_r == CODE_RESUME))
                                       ? epc_r : exc_addr_r;
            default: exc_addr_next_s = exc_addr_r;
        endcase
    end

    // Architectural registers and registered pipeline-control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_r       <= 1'b1;
            exl_r      <= 1'b0;
            im_r       <= 8'hFF;
            ip_r       <= 8'h00;
            bd_r       <= 1'b0;
            code_r     <= 5'd0;
            epc_r      <= 32'h0000_0000;
            flush_r    <= 1'b0;
            ex_wb_r    <= 1'b0;
            eret_r     <= 1'b0;
            hlt_r      <= 1'b0;
            exc_addr_r <= EXC_VECTOR;
        end else begin
            ie_r       <= ie_next_s;
            exl_r      <= exl_next_s;
            im_r       <= im_next_s;
            ip_r       <= ip_next_s;
            bd_r       <= bd_next_s;
            code_r     <= code_next_s;
            epc_r      <= epc_next_s;
            flush_r    <= flush_next_s;
            ex_wb_r    <= ex_wb_next_s;
            eret_r     <= eret_next_s;
            hlt_r      <= hlt_next_s;
            exc_addr_r <= exc_addr_next_s;
        end
    end

    // MFC0 read mux; unimplemented indices and bits read as zero.
    always_comb begin
        case (cp0_rdc)
            IDX_STATUS: cp0_rdata = {16'h0000, im_r, 6'b000000, exl_r, ie_r};
            IDX_CAUSE:  cp0_rdata = {bd_r, 15'h0000, ip_r, 1'b0, code_r, 2'b00};
            IDX_EPC:    cp0_rdata = epc_r;
            default:    cp0_rdata = 32'h0000_0000;
        endcase
    end

    assign cp0_flush    = flush_r;
    assign ex_wb        = ex_wb_r;
    assign cp0_eret     = eret_r;
    assign cp0_hlt      = hlt_r;
    assign cp0_ie       = ie_r;
    assign cp0_exl      = exl_r;
    assign cp0_int_mask = im_r;
    assign cp0_int_sig  = ip_r;
    assign exc_addr     = exc_addr_r;

endmodule
